// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and default timing for the SPI transaction arbiter.
//   state_e   : arbiter FSM states (IDLE, XFER, GAP)
//   spi_req_t : one requester's transaction fields {rd_wr, addr, wdata}
//   DEF_FRAME_CYCLES / DEF_GAP_CYCLES : default start-high / start-low lengths
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic       rd_wr;
    logic [6:0] addr;
    logic [7:0] wdata;
  } spi_req_t;

  localparam int DEF_FRAME_CYCLES = 18;
  localparam int DEF_GAP_CYCLES   = 2;

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: picks one requester per cycle.
// Build option: SPI_ARB_RR_EN defined  -> round-robin, search starts at an
//               internal pointer that moves to (winner+1) mod NUM_REQ after
//               every grant.
//               SPI_ARB_RR_EN undefined -> fixed priority, lowest index wins;
//               no pointer, no clock or reset ports.
// Ports:
//   mclk, reset : clock / synchronous active-high reset (round-robin build only)
//   req         : masked request vector (caller zeroes it when no grant may issue)
//   grant       : one-hot grant, zero when nothing requested
//   grant_idx   : binary index of the granted requester
//   grant_any   : a grant is being issued this cycle
module spi_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
`ifdef SPI_ARB_RR_EN
  input  logic                mclk,
  input  logic                reset,
`endif
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_W-1:0]     grant_idx,
  output logic                grant_any
);

`ifdef SPI_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  int              dist;
  int              best;

  // Winner is the requester with the smallest circular distance from the pointer.
  always_comb begin
    best      = NUM_REQ;
    dist      = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist = i - int'(ptr_q);
      if (dist < 0) dist = dist + NUM_REQ;
      if (req[i] && (dist < best)) begin
        best      = dist;
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end

  // The caller only presents requests when a handshake can happen, so any
  // grant is a real handshake and advances the pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  // Scan from the top so the lowest set index is the last, winning assignment.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign grant[gi] = grant_any && (grant_idx == ID_W'(gi));
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI master between NUM_REQ requesters.
// A grant in IDLE latches the winner's {rd_wr, addr, wdata}; start is then held
// high for FRAME_CYCLES cycles, low for GAP_CYCLES cycles, and a one-cycle
// rsp_valid pulse reports the completed transaction in the first gap cycle.
// Build option: SPI_ARB_RR_EN selects round-robin arbitration (default build:
// fixed priority, lowest index wins).
// Ports:
//   mclk, reset          : clock / synchronous active-high reset
//   req_valid/req_ready  : per-requester request / one-cycle accept strobe
//   req_rd_wr/addr/wdata : per-requester transaction fields (1 = read)
//   rsp_valid/id/rdata   : completion pulse, requester index, read data (0 on writes)
//   busy                 : any state other than IDLE
//   start, master_*      : drive to the SPI master; master_in_data is its read data
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter  int GAP_CYCLES   = DEF_GAP_CYCLES,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    mclk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_rd_wr,
  input  logic [NUM_REQ-1:0][6:0] req_addr,
  input  logic [NUM_REQ-1:0][7:0] req_wdata,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [7:0]              rsp_rdata,
  output logic                    busy,
  output logic                    start,
  output logic                    master_rd_wr,
  output logic [6:0]              master_address,
  output logic [7:0]              master_out_data,
  input  logic [7:0]              master_in_data
);

  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  spi_req_t         txn_q, txn_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;

  spi_req_t         req_vec [NUM_REQ];
  spi_req_t         sel_req;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
    assign req_vec[gi] = '{rd_wr: req_rd_wr[gi], addr: req_addr[gi], wdata: req_wdata[gi]};
  end

  // Requests reach the arbiter only in IDLE and outside reset, so a grant is
  // exactly a handshake and reset suppresses req_ready in the same cycle.
  assign arb_req = (state_q == IDLE && !reset) ? req_valid : '0;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef SPI_ARB_RR_EN
    .mclk      (mclk),
    .reset     (reset),
`endif
    .req       (arb_req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grant is one-hot, so an OR of the masked fields selects the winner.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_req = req_vec[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    txn_d       = txn_q;
    id_d        = id_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = XFER;
          cnt_d   = '0;
          txn_d   = sel_req;
          id_d    = grant_idx;
        end
      end
      XFER: begin
        if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
          state_d     = GAP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_rdata_d = txn_q.rd_wr ? master_in_data : 8'h00;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      txn_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txn_q       <= txn_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready       = grant;
  assign busy            = (state_q != IDLE);
  assign start           = (state_q == XFER);
  assign master_rd_wr    = txn_q.rd_wr;
  assign master_address  = txn_q.addr;
  assign master_out_data = txn_q.wdata;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_rdata       = rsp_rdata_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed scenarios plus a randomized run checked against
// a transaction-timeline model (handshake at T, start high T+1..T+F, response
// at T+F+1, next handshake no earlier than T+F+G+1).
module tb_spi_txn_arbiter;
  localparam int N  = 4;
  localparam int F  = 18;
  localparam int G  = 2;
  localparam int IW = 2;
`ifdef SPI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              mclk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready, req_rd_wr;
  logic [N-1:0][6:0] req_addr;
  logic [N-1:0][7:0] req_wdata;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [7:0]        rsp_rdata;
  logic              busy, start, master_rd_wr;
  logic [6:0]        master_address;
  logic [7:0]        master_out_data, master_in_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_ptr = 0;

  always #5 mclk = ~mclk;

  spi_txn_arbiter #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
    .mclk(mclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_wr(req_rd_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .busy(busy),
    .start(start), .master_rd_wr(master_rd_wr), .master_address(master_address),
    .master_out_data(master_out_data), .master_in_data(master_in_data)
  );

  // Expected winner: rotate from the pointer (round-robin) or scan from 0.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = RR ? (ptr + k) % N : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int next_ptr(input int g);
    return RR ? (g + 1) % N : 0;
  endfunction

  task automatic tick();
    @(posedge mclk); #1; cyc++;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rd_wr = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); req_valid = '1; master_in_data = 8'h5A;
    repeat (3) tick();
    @(negedge mclk);
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    n_cmp++; if ({busy, start, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_ctrl got=%b exp=000", {busy, start, rsp_valid}); end
    n_cmp++; if ({rsp_id, rsp_rdata} !== '0) begin n_bad++; $display("FAIL rst_rsp got=%h exp=0", {rsp_id, rsp_rdata}); end
    n_cmp++; if ({master_rd_wr, master_address, master_out_data} !== '0) begin n_bad++; $display("FAIL rst_master got=%h exp=0", {master_rd_wr, master_address, master_out_data}); end
    tick(); reset = 1'b0; req_valid = '0; model_ptr = 0;
    @(negedge mclk);
    n_cmp++; if ({busy, start, req_ready} !== '0) begin n_bad++; $display("FAIL rst_idle got=%b exp=0", {busy, start, req_ready}); end
    $display("test_reset done cyc=%0d", cyc);
  endtask

  task automatic test_single_write();
    tick(); master_in_data = 8'hFF;
    req_valid[1] = 1'b1; req_rd_wr[1] = 1'b0; req_addr[1] = 7'h2A; req_wdata[1] = 8'hC3;
    @(negedge mclk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL wr_ready got=%b exp=0010", req_ready); end
    model_ptr = next_ptr(1);
    for (int k = 1; k <= F + G + 1; k++) begin
      tick(); if (k == 1) idle_inputs();
      @(negedge mclk);
      n_cmp++; if (start !== (k <= F)) begin n_bad++; $display("FAIL wr_start k=%0d got=%b exp=%b", k, start, (k <= F)); end
      n_cmp++; if (busy !== (k <= F + G)) begin n_bad++; $display("FAIL wr_busy k=%0d got=%b exp=%b", k, busy, (k <= F + G)); end
      n_cmp++; if (rsp_valid !== (k == F + 1)) begin n_bad++; $display("FAIL wr_rspv k=%0d got=%b exp=%b", k, rsp_valid, (k == F + 1)); end
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL wr_noready k=%0d got=%b exp=0000", k, req_ready); end
      if (k <= F + G) begin
        n_cmp++; if ({master_rd_wr, master_address, master_out_data} !== {1'b0, 7'h2A, 8'hC3}) begin n_bad++; $display("FAIL wr_master k=%0d got=%h exp=2ac3", k, {master_rd_wr, master_address, master_out_data}); end
      end
      if (k == F + 1) begin
        n_cmp++; if ({rsp_id, rsp_rdata} !== {2'd1, 8'h00}) begin n_bad++; $display("FAIL wr_rsp got=id%0d/%h exp=id1/00", rsp_id, rsp_rdata); end
      end
    end
    $display("test_single_write done cyc=%0d", cyc);
  endtask

  task automatic test_single_read();
    int highs;
    highs = 0;
    tick(); master_in_data = 8'h9E;
    req_valid[0] = 1'b1; req_rd_wr[0] = 1'b1; req_addr[0] = 7'h05; req_wdata[0] = 8'h77;
    @(negedge mclk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rd_ready got=%b exp=0001", req_ready); end
    model_ptr = next_ptr(0);
    for (int k = 1; k <= F + G + 1; k++) begin
      tick(); if (k == 1) idle_inputs();
      @(negedge mclk);
      if (start === 1'b1) highs++;
      if (k == 1) begin
        n_cmp++; if ({master_rd_wr, master_address} !== {1'b1, 7'h05}) begin n_bad++; $display("FAIL rd_master got=%h exp=85", {master_rd_wr, master_address}); end
      end
      if (k == F + 1) begin
        n_cmp++; if ({rsp_valid, rsp_id, rsp_rdata} !== {1'b1, 2'd0, 8'h9E}) begin n_bad++; $display("FAIL rd_rsp got=v%b id%0d %h exp=v1 id0 9e", rsp_valid, rsp_id, rsp_rdata); end
      end
      if (k == F + G + 1) begin
        n_cmp++; if ({rsp_valid, rsp_id, rsp_rdata} !== {1'b0, 2'd0, 8'h9E}) begin n_bad++; $display("FAIL rd_hold got=v%b id%0d %h exp=v0 id0 9e", rsp_valid, rsp_id, rsp_rdata); end
      end
    end
    n_cmp++; if (highs != F) begin n_bad++; $display("FAIL rd_start_len got=%0d exp=%0d", highs, F); end
    $display("test_single_read done cyc=%0d", cyc);
  endtask

  task automatic test_arbitration();
    logic [N-1:0] v;
    int grants, last_t, exp_g;
    grants = 0; last_t = -1; v = '1;
    tick(); req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_rd_wr[i] = 1'($urandom); req_addr[i] = 7'($urandom); req_wdata[i] = 8'($urandom);
    end
    for (int c = 0; c < 200 && grants < 4; c++) begin
      @(negedge mclk);
      if (req_ready !== '0) begin
        exp_g = pick(v, model_ptr);
        n_cmp++; if (req_ready !== (N'(1) << exp_g)) begin n_bad++; $display("FAIL arb_grant n=%0d got=%b exp_idx=%0d", grants, req_ready, exp_g); end
        if (last_t >= 0) begin
          n_cmp++; if (cyc - last_t != F + G + 1) begin n_bad++; $display("FAIL arb_spacing got=%0d exp=%0d", cyc - last_t, F + G + 1); end
        end
        $display("arb grant n=%0d idx_exp=%0d ready=%b cyc=%0d", grants, exp_g, req_ready, cyc);
        last_t = cyc; grants++; model_ptr = next_ptr(exp_g);
        if (RR) v[exp_g] = 1'b0;
      end
      tick(); req_valid = v;
    end
    n_cmp++; if (grants != 4) begin n_bad++; $display("FAIL arb_count got=%0d exp=4", grants); end
    req_valid = '0;
    repeat (F + G + 2) tick();
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    bit rsp_seen;
    t2 = -1; rsp_seen = 1'b0;
    tick(); req_valid[2] = 1'b1; req_rd_wr[2] = 1'b0; req_addr[2] = 7'h11; req_wdata[2] = 8'h22;
    @(negedge mclk); t1 = cyc;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL b2b_ready1 got=%b exp=0100", req_ready); end
    model_ptr = next_ptr(2);
    tick(); req_valid[2] = 1'b0;
    for (int c = 0; c < 3 * (F + G); c++) begin
      @(negedge mclk);
      if (req_ready !== '0) begin t2 = cyc; break; end
      if (rsp_valid === 1'b1) rsp_seen = 1'b1;
      tick();
      if (rsp_seen) req_valid[2] = 1'b1;
    end
    n_cmp++; if (t2 - t1 != F + G + 1) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=%0d", t2 - t1, F + G + 1); end
    n_cmp++; if ({req_ready, start} !== {4'b0100, 1'b0}) begin n_bad++; $display("FAIL b2b_ready2 got=%b/%b exp=0100/0", req_ready, start); end
    model_ptr = next_ptr(2);
    tick(); req_valid[2] = 1'b0;
    @(negedge mclk);
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL b2b_restart got=%b exp=1", start); end
    $display("test_back_to_back t1=%0d t2=%0d", t1, t2);
    repeat (F + G + 1) tick();
  endtask

  task automatic test_field_change();
    tick(); req_valid[3] = 1'b1; req_rd_wr[3] = 1'b1; req_addr[3] = 7'h33; req_wdata[3] = 8'h44;
    @(negedge mclk);
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL fc_ready got=%b exp=1000", req_ready); end
    model_ptr = next_ptr(3);
    for (int k = 1; k <= F + G; k++) begin
      tick(); req_valid = '0;
      for (int i = 0; i < N; i++) begin
        req_rd_wr[i] = 1'($urandom); req_addr[i] = 7'($urandom); req_wdata[i] = 8'($urandom);
      end
      @(negedge mclk);
      n_cmp++; if ({master_rd_wr, master_address, master_out_data} !== {1'b1, 7'h33, 8'h44}) begin n_bad++; $display("FAIL fc_master k=%0d got=%h exp=b344", k, {master_rd_wr, master_address, master_out_data}); end
    end
    tick(); idle_inputs();
    $display("test_field_change done cyc=%0d", cyc);
  endtask

  task automatic test_reset_mid_xfer();
    tick(); req_valid[1] = 1'b1; req_rd_wr[1] = 1'b0; req_addr[1] = 7'h3C; req_wdata[1] = 8'h5D;
    @(negedge mclk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rm_ready got=%b exp=0010", req_ready); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      if (k == 10) reset = 1'b1;
      @(negedge mclk);
    end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL rm_pre got=%b exp=1", start); end
    tick(); reset = 1'b0; model_ptr = 0;
    @(negedge mclk);
    n_cmp++; if ({start, busy} !== 2'b00) begin n_bad++; $display("FAIL rm_abort got=%b exp=00", {start, busy}); end
    n_cmp++; if ({master_address, master_out_data, rsp_id, rsp_rdata} !== '0) begin n_bad++; $display("FAIL rm_clear got=%h exp=0", {master_address, master_out_data, rsp_id, rsp_rdata}); end
    for (int k = 0; k < F + G; k++) begin
      tick(); @(negedge mclk);
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rm_norsp k=%0d got=%b exp=00", k, {rsp_valid, busy}); end
    end
    tick(); req_valid = '1;
    @(negedge mclk);
    n_cmp++; if (req_ready !== (N'(1) << pick('1, model_ptr))) begin n_bad++; $display("FAIL rm_ptr got=%b exp=0001", req_ready); end
    model_ptr = next_ptr(pick('1, model_ptr));
    tick(); req_valid = '0;
    repeat (F + G + 1) tick();
    $display("test_reset_mid_xfer done cyc=%0d", cyc);
  endtask

  task automatic test_random();
    logic [N-1:0] pend, rd;
    logic [6:0]   ad [N];
    logic [7:0]   wd [N];
    logic [15:0]  cur;
    logic [7:0]   last_rd, mid_prev;
    logic [N-1:0] exp_ready;
    int next_free, t, g, last_id, ntx;
    bit grant_now, in_x, in_b;
    tick(); reset = 1'b1; idle_inputs();
    tick(); reset = 1'b0;
    model_ptr = 0; pend = '0; rd = '0; last_id = 0; last_rd = 8'h00; t = -100; g = 0; ntx = 0;
    next_free = cyc; cur = '0;
    for (int i = 0; i < N; i++) begin ad[i] = '0; wd[i] = '0; end
    for (int c = 0; c < 4000 && ntx < 50; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b1; rd[i] = 1'($urandom); ad[i] = 7'($urandom); wd[i] = 8'($urandom);
        end
        req_rd_wr[i] = pend[i] ? rd[i] : 1'($urandom);
        req_addr[i]  = pend[i] ? ad[i] : 7'($urandom);
        req_wdata[i] = pend[i] ? wd[i] : 8'($urandom);
      end
      req_valid = pend;
      mid_prev = master_in_data; master_in_data = 8'($urandom);
      @(negedge mclk);
      grant_now = 1'b0;
      if (cyc >= next_free && pend != '0) begin
        g = pick(pend, model_ptr); t = cyc; grant_now = 1'b1;
        cur = {rd[g], ad[g], wd[g]}; next_free = cyc + F + G + 1; model_ptr = next_ptr(g);
      end
      exp_ready = grant_now ? (N'(1) << g) : '0;
      in_x = (cyc >= t + 1) && (cyc <= t + F);
      in_b = (cyc >= t + 1) && (cyc <= t + F + G);
      if (cyc == t + F + 1) begin
        last_id = g; last_rd = cur[15] ? mid_prev : 8'h00; ntx++;
        $display("rnd txn %0d id=%0d rd=%b addr=%h wdata=%h rdata_exp=%h got=%h", ntx, g, cur[15], cur[14:8], cur[7:0], last_rd, rsp_rdata);
      end
      n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
      n_cmp++; if ({start, busy} !== {in_x, in_b}) begin n_bad++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {start, busy}, {in_x, in_b}); end
      n_cmp++; if (rsp_valid !== (cyc == t + F + 1)) begin n_bad++; $display("FAIL rnd_rspv cyc=%0d got=%b", cyc, rsp_valid); end
      n_cmp++; if ({rsp_id, rsp_rdata} !== {IW'(last_id), last_rd}) begin n_bad++; $display("FAIL rnd_rsp cyc=%0d got=id%0d/%h exp=id%0d/%h", cyc, rsp_id, rsp_rdata, last_id, last_rd); end
      if (in_b) begin
        n_cmp++; if ({master_rd_wr, master_address, master_out_data} !== cur) begin n_bad++; $display("FAIL rnd_master cyc=%0d got=%h exp=%h", cyc, {master_rd_wr, master_address, master_out_data}, cur); end
      end
      if (grant_now) pend[g] = 1'b0;
      tick();
    end
    n_cmp++; if (ntx != 50) begin n_bad++; $display("FAIL rnd_count got=%0d exp=50", ntx); end
    idle_inputs();
    repeat (G + 2) tick();
  endtask

  initial begin
    reset = 1'b1; idle_inputs(); master_in_data = 8'h00;
    test_reset();
    test_single_write();
    test_single_read();
    test_arbitration();
    test_back_to_back();
    test_field_change();
    test_reset_mid_xfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
